// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: AES/Rijndael ShiftRows (and optionally InvShiftRows) on an NB-column state.
// Latency: 1 cycle from transfer in to out_valid; permutation is combinational ahead of the main register.
// Backpressure: main register plus one skid entry; in_ready drops only when both are full, and in_ready never depends on out_ready.
//
// Ports: clk/rst (synchronous, active-high reset); in_valid/in_ready/in_inv/in_state upstream;
//        out_valid/out_ready/out_state/out_inv downstream. Byte k = 4*col + row sits at bits [8k+7:8k].
// Build option: define SHIFT_ROWS_INV_EN to build the inverse permutation selected by in_inv.
//        Without it, in_inv is ignored and out_inv is constant 0.
module shift_rows_pipe #(
    parameter  int NB = 4,
    localparam int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [W-1:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_state,
    output logic         out_inv
);

    // Only the Rijndael block sizes with defined row offsets are accepted.
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    // Row shift offset; the 256-bit block uses a wider spread for rows 2 and 3.
    function automatic int row_off(input int r);
        case (r)
            1:       return 1;
            2:       return (NB == 8) ? 3 : 2;
            3:       return (NB == 8) ? 4 : 3;
            default: return 0;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic           main_inv_q, main_inv_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           skid_inv_q, skid_inv_d;

    logic [W-1:0]   fwd_perm;
    logic [W-1:0]   perm;
    logic           perm_inv;
    logic           in_fire;
    logic           load_main_in;
    logic           load_skid_in;
    logic           load_main_skid;

    // Forward: out(r,c) = in(r,(c+Cr) mod NB)
    always_comb begin
        fwd_perm = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                fwd_perm[8*(4*c+r) +: 8] = in_state[8*(4*((c + row_off(r)) % NB) + r) +: 8];
            end
        end
    end

`ifdef SHIFT_ROWS_INV_EN
    logic [W-1:0] inv_perm;

    // Inverse: out(r,c) = in(r,(c-Cr) mod NB); +NB keeps the operand non-negative.
    always_comb begin
        inv_perm = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                inv_perm[8*(4*c+r) +: 8] = in_state[8*(4*((c + NB - row_off(r)) % NB) + r) +: 8];
            end
        end
    end

    assign perm     = in_inv ? inv_perm : fwd_perm;
    assign perm_inv = in_inv;
`else
    logic unused_in_inv;

    assign unused_in_inv = in_inv;
    assign perm          = fwd_perm;
    assign perm_inv      = 1'b0;
`endif

    // in_ready comes from the state register only (plus reset), never from out_ready.
    assign in_ready  = !rst && (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_state = main_q;
    assign out_inv   = main_inv_q;

    // Occupancy FSM. out_valid is implied in ONE/TWO, so out_ready alone means a transfer out there.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    state_d      = S_ONE;
                    load_main_in = 1'b1;
                end
            end
            S_ONE: begin
                if (in_fire && out_ready) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    state_d      = S_TWO;
                    load_skid_in = 1'b1;
                end else if (out_ready) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (out_ready) begin
                    state_d        = S_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    always_comb begin
        main_d     = main_q;
        main_inv_d = main_inv_q;
        skid_d     = skid_q;
        skid_inv_d = skid_inv_q;
        if (load_main_in) begin
            main_d     = perm;
            main_inv_d = perm_inv;
        end
        if (load_main_skid) begin
            main_d     = skid_q;
            main_inv_d = skid_inv_q;
        end
        if (load_skid_in) begin
            skid_d     = perm;
            skid_inv_d = perm_inv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            main_inv_q <= 1'b0;
            skid_q     <= '0;
            skid_inv_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            main_inv_q <= main_inv_d;
            skid_q     <= skid_d;
            skid_inv_q <= skid_inv_d;
        end
    end

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, meaning the number of state columns; legal values are 4, 6 and 8.
REQ-002 SHALL have localparam W = 32*NB, meaning the state width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream state is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a state this cycle.
REQ-007 SHALL have port in_inv, input, 1 bit: 0 selects ShiftRows, 1 selects InvShiftRows; it is sampled with the state.
REQ-008 SHALL have port in_state, input, W bits: input state; byte k = 4c+r sits at bits [8k+7:8k], for row r and column c.
REQ-009 SHALL have port out_valid, output, 1 bit: out_state holds a result.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_state, output, W bits: the permuted state, in the same byte layout as in_state.
REQ-012 SHALL have port out_inv, output, 1 bit: the in_inv value that travelled with this result.

Function
REQ-013 SHALL use row shift offsets C1,C2,C3 = 1,2,3 for NB=4 and NB=6, and 1,3,4 for NB=8; row 0 is never shifted.
REQ-014 Forward mode SHALL compute out(r,c) = in(r,(c+Cr) mod NB).
REQ-015 Inverse mode SHALL compute out(r,c) = in(r,(c-Cr) mod NB); column indices wrap modulo NB.
REQ-016 SHALL perform a transfer in when in_valid && in_ready, and a transfer out when out_valid && out_ready.
REQ-017 SHALL compute the permutation combinationally before the register, so latency from transfer in to out_valid is exactly 1 cycle.
REQ-018 SHALL contain a main output register and a single-entry skid register; out_state and out_inv come directly from the main register, with no combinational path from in_state.
REQ-019 SHALL track occupancy with a 3-state FSM: EMPTY, ONE (main full), TWO (main + skid full).
REQ-020 FSM transitions:
- EMPTY + in -> ONE
- ONE + in, no out -> TWO
- ONE + in + out -> ONE (main reloaded)
- ONE + out, no in -> EMPTY
- TWO + out -> ONE (skid moves to main)
- all other cases hold state
REQ-021 in_ready SHALL equal (state != TWO), registered-derived, with no combinational dependency on out_ready.
REQ-022 In state TWO, a new transfer in SHALL be impossible.
REQ-023 SHALL sustain one state per cycle when out_ready is continuously 1.
REQ-024 out_valid = (state != EMPTY).
REQ-025 While out_valid && !out_ready, out_state and out_inv SHALL hold stable.
REQ-026 Results SHALL leave in acceptance order; no loss or duplication under any valid/ready pattern.
REQ-027 in_inv SHALL be able to change every accepted state; each result uses its own sampled mode.
REQ-028 NB outside {4,6,8} SHALL fail elaboration.

Reset
REQ-029 On rst=1 at a clock edge: FSM -> EMPTY, out_valid=0, in_ready=1, out_state=0, out_inv=0, skid cleared.
REQ-030 Reset SHALL take priority over any simultaneous transfer; data in flight is discarded.
REQ-031 While rst=1, in_ready SHALL read 0.

Configuration
REQ-032 With macro SHIFT_ROWS_INV_EN defined, inverse mode SHALL be implemented per REQ-015.
REQ-033 Without SHIFT_ROWS_INV_EN, in_inv SHALL be ignored, only the forward permutation is built, and out_inv SHALL be constant 0.

Verification
REQ-034 NB=4, forward, in_state=0x0f0e..0100 (byte k=k), out_ready=1 -> one cycle later out_state bytes [0..15] = 00,05,0a,0f,04,09,0e,03,08,0d,02,07,0c,01,06,0b.
REQ-035 NB=4, inverse applied to the REQ-034 output -> returns 0x0f0e..0100, with out_inv=1.
REQ-036 NB=8, forward, byte k=k -> out(3,0) = byte 19 (row 3, col 4) and out(2,7) = byte 10 (row 2, col 2); a forward then inverse round trip returns the original state.
REQ-037 Backpressure: three states accepted back-to-back with out_ready=0 -> in_ready drops after the 2nd; out_state holds the 1st; releasing out_ready yields 1st, 2nd, 3rd in order.
REQ-038 Random valid/ready, 10k states, in_inv random -> every output matches the scoreboard; throughput is 1 per cycle when out_ready=1.
REQ-039 rst asserted in state TWO -> next cycle out_valid=0, out_state=0, in_ready=1 after release; no stale output ever appears.
